shift_unit_seq: RTL and testbench

Parametrised, multi-cycle shift engine for the MIPS32 ALU datapath. It supports logical-left, logical-right, arithmetic-right and rotate-right modes. It accepts a full-width shift-amount operand and saturates out-of-range amounts the same way the combinational SRA path does. It resolves one log2 stage per clock and exchanges operands and results over valid/ready handshakes, so the execute stage can stall on it.

---
 rtl/shift_unit_seq.sv | 173 +++++++++++++++++
 tb/tb_shift_unit_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//
// Multi-cycle shift engine for the ALU datapath. It supports logical left,
// logical right, arithmetic right and rotate right. One power-of-two stage
// (1, 2, 4, ...) is resolved per clock. Operands and results move over
// valid/ready handshakes, so the execute stage can stall on the result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   block can accept an operand (IDLE only, and not during reset)
//   in_data    value to shift
//   in_amt     full-width shift amount; upper bits only signal saturation
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   out_data   shifted result (zero when out_valid is low)
//   busy       high in SHIFT or DONE
// -----------------------------------------------------------------------------
module shift_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W[SHAMT_W-1:0] - 1'b1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_data_next;
  logic [SHAMT_W-1:0] r_amt;
  logic [SHAMT_W-1:0] w_amt_next;
  logic [1:0]         r_mode;
  logic [1:0]         w_mode_next;
  logic [SHAMT_W-1:0] r_k;
  logic [SHAMT_W-1:0] w_k_next;
  // Goes high on the first clock after reset release; keeps in_ready low
  // while the block is held in reset even though the state reads IDLE.
  logic               r_live;

  logic               w_ovf;
  logic [WIDTH-1:0]   w_fill;
  logic [WIDTH-1:0]   w_shifted;

  // Every stage candidate is a fixed-distance shift of r_data; the stage
  // counter picks which one is applied this clock.
  logic [SHAMT_W-1:0][WIDTH-1:0] w_stage;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int S = 1 << gi;
      logic [WIDTH-1:0] w_sll;
      logic [WIDTH-1:0] w_srl;
      logic [WIDTH-1:0] w_sra;
      logic [WIDTH-1:0] w_ror;

      assign w_sll = {r_data[WIDTH-1-S:0], {S{1'b0}}};
      assign w_srl = {{S{1'b0}}, r_data[WIDTH-1:S]};
      assign w_sra = {{S{r_data[WIDTH-1]}}, r_data[WIDTH-1:S]};
      assign w_ror = {r_data[S-1:0], r_data[WIDTH-1:S]};

      assign w_stage[gi] = (r_mode == MODE_SLL) ? w_sll :
                           (r_mode == MODE_SRL) ? w_srl :
                           (r_mode == MODE_SRA) ? w_sra : w_ror;
    end
  endgenerate

  // Apply the current stage only when its amount bit is set; otherwise hold.
  always_comb begin
    w_shifted = r_data;
    for (int i = 0; i < SHAMT_W; i++) begin
      if ((r_k == i[SHAMT_W-1:0]) && r_amt[i]) begin
        w_shifted = w_stage[i];
      end
    end
  end

  // Any amount >= WIDTH saturates. The result is then the fill pattern, so it
  // is loaded directly and the stages run with a zero amount. Latency stays
  // fixed.
  assign w_ovf  = |in_amt[WIDTH-1:SHAMT_W];
  assign w_fill = (in_mode == MODE_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_amt_next   = r_amt;
    w_mode_next  = r_mode;
    w_k_next     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (w_ovf && (in_mode != MODE_ROR)) begin
            w_data_next = w_fill;
            w_amt_next  = '0;
          end else begin
            w_data_next = in_data;
            w_amt_next  = in_amt[SHAMT_W-1:0];
          end
          w_mode_next  = in_mode;
          w_k_next     = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_data_next = w_shifted;
        w_k_next    = r_k + 1'b1;
        if (r_k == K_LAST) begin
          w_k_next     = '0;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= MODE_SLL;
      r_k     <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_amt   <= w_amt_next;
      r_mode  <= w_mode_next;
      r_k     <= w_k_next;
      r_live  <= 1'b1;
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && r_live;
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = out_valid ? r_data : '0;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_seq
//
// Directed bench for shift_unit_seq (WIDTH = 32). A transaction-level model
// tracks one in-flight operation. It holds the architectural result of the
// shift and the number of clocks since accept. From these it predicts
// in_ready, out_valid, busy and out_data on every falling edge. The directed
// operations also check each result against a hand-computed literal.
// -----------------------------------------------------------------------------
module tb_shift_unit_seq;

  localparam int LAT = 5;  // clocks from accept edge to out_valid

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] in_amt = '0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  shift_unit_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain shift arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] a,
                                            input logic [1:0] m);
    int s;
    logic [31:0] r;
    if (m == 2'b11) begin
      s = int'(a % 32);
      r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    end else if (a >= 32) begin
      r = (m == 2'b10 && d[31]) ? 32'hFFFF_FFFF : 32'h0;
    end else begin
      case (m)
        2'b00:   r = d << a;
        2'b01:   r = d >> a;
        default: r = $signed(d) >>> a;
      endcase
    end
    return r;
  endfunction

  // Transaction model: one slot, an age counter and the predicted result.
  bit          m_busy = 1'b0;
  bit          m_live = 1'b0;
  int          m_age = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] last_out = '0;
  int          acc_cnt = 0;
  int          done_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_live <= 1'b0;
      m_age  <= 0;
    end else begin
      m_live <= 1'b1;
      if (!m_busy) begin
        if (in_valid && m_live) begin
          m_busy  <= 1'b1;
          m_age   <= 0;
          m_exp   <= ref_shift(in_data, in_amt, in_mode);
          acc_cnt <= acc_cnt + 1;
        end
      end else if (m_age >= LAT && out_ready) begin
        m_busy   <= 1'b0;
        done_cnt <= done_cnt + 1;
        last_out <= out_data;
      end else if (m_age < LAT) begin
        m_age <= m_age + 1;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  logic        e_valid;
  logic        e_ready;
  logic [31:0] e_data;
  always @(negedge clk) begin
    e_valid = m_busy && (m_age >= LAT);
    e_ready = !m_busy && m_live;
    e_data  = e_valid ? m_exp : 32'h0;
    chk("cyc out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    chk("cyc in_ready",  {31'b0, in_ready},  {31'b0, e_ready});
    chk("cyc busy",      {31'b0, busy},      {31'b0, m_busy});
    chk("cyc out_data",  out_data, e_data);
  end

  // Single operation with out_ready held high. Called #1 after a rising edge
  // with the DUT idle, so the accept is on the next edge and the handshake
  // completes LAT+1 edges after that.
  task automatic op(input string name, input logic [31:0] d, input logic [31:0] a,
                    input logic [1:0] m, input logic [31:0] lit);
    int sa;
    int sd;
    int cyc;
    bit ok;
    sa = acc_cnt;
    sd = done_cnt;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      ok = (acc_cnt != sa);
    end
    in_valid = 1'b0;
    chk({name, " accept_wait"}, 32'(cyc), 32'd1);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      ok = (done_cnt != sd);
    end
    chk({name, " latency"}, 32'(cyc), 32'(LAT + 1));
    chk({name, " result"}, last_out, lit);
    $display("op %-12s data=%h amt=%h mode=%0d -> %h (want %h)", name, d, a, m, last_out, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa;
    int sd;
    int cyc;
    bit ok;

    // Reset state, while rst_n is still low.
    #2;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy",      {31'b0, busy},      32'd0);
    chk("rst in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst out_data",  out_data, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // Pin the model itself to hand-computed values.
    chk("model sra", ref_shift(32'h8000_0010, 32'd4, 2'b10), 32'hF800_0001);
    chk("model ror", ref_shift(32'h1234_5678, 32'h24, 2'b11), 32'h8123_4567);
    chk("model sat", ref_shift(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10), 32'h0);

    op("sra4",      32'h8000_0010, 32'd4,         2'b10, 32'hF800_0001);
    op("sra_sat",   32'h8000_0000, 32'h20,        2'b10, 32'hFFFF_FFFF);
    op("srl_sat",   32'h8000_0000, 32'h20,        2'b01, 32'h0000_0000);
    op("sll_sat",   32'h0000_0001, 32'h100,       2'b00, 32'h0000_0000);
    op("sra_satp",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000);
    op("ror36",     32'h1234_5678, 32'h24,        2'b11, 32'h8123_4567);
    op("ror0",      32'h1234_5678, 32'h0,         2'b11, 32'h1234_5678);
    op("sll31",     32'h0000_0001, 32'd31,        2'b00, 32'h8000_0000);
    op("srl31",     32'h8000_0000, 32'd31,        2'b01, 32'h0000_0001);
    op("srl8",      32'h1234_5678, 32'd8,         2'b01, 32'h0012_3456);
    op("sra8",      32'hF000_0000, 32'd8,         2'b10, 32'hFFF0_0000);
    op("sll4",      32'h1234_5678, 32'd4,         2'b00, 32'h2345_6780);
    op("ror1",      32'h0000_0001, 32'd1,         2'b11, 32'h8000_0000);
    op("sll0",      32'hDEAD_BEEF, 32'd0,         2'b00, 32'hDEAD_BEEF);

    // Backpressure: hold out_ready low for 10 clocks with in_valid pulses.
    sa = acc_cnt;
    sd = done_cnt;
    out_ready = 1'b0;
    in_data   = 32'hF000_0000;
    in_amt    = 32'd4;
    in_mode   = 2'b01;
    in_valid  = 1'b1;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      ok = (acc_cnt != sa);
    end
    in_valid = 1'b0;
    chk("bp accept", {31'b0, ok}, 32'd1);
    cyc = 0;
    while (!(m_busy && m_age >= LAT) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp valid_wait", 32'(cyc), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      in_data  = 32'h5555_0000 + 32'(i);
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp out_data",  out_data, 32'h0F00_0000);
      chk("bp in_ready",  {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp no_accept", 32'(acc_cnt), 32'(sa + 1));
    chk("bp no_done",   32'(done_cnt), 32'(sd));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp done",     32'(done_cnt), 32'(sd + 1));
    chk("bp result",   last_out, 32'h0F00_0000);
    chk("bp in_ready", {31'b0, in_ready}, 32'd1);
    $display("op %-12s data=%h amt=%h mode=%0d -> %h (want %h)", "backpress",
             32'hF000_0000, 32'd4, 1, last_out, 32'h0F00_0000);

    // Reset asserted two clocks after accept aborts the operation.
    @(posedge clk); #1;
    sa = acc_cnt;
    sd = done_cnt;
    in_data  = 32'h0000_00FF;
    in_amt   = 32'd4;
    in_mode  = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst-op accept", 32'(acc_cnt), 32'(sa + 1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst-op busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst-op out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst-op out_data",  out_data, 32'd0);
    chk("rst-op busy",      {31'b0, busy}, 32'd0);
    chk("rst-op in_ready",  {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst-op no_result", 32'(done_cnt), 32'(sd));
    $display("op %-12s aborted by reset, results emitted=%0d (want 0)", "rst_abort", done_cnt - sd);
    op("sll_after", 32'h0000_0003, 32'd2, 2'b00, 32'h0000_000C);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
